lif_neuron_fp32: RTL

//  Leaky integrate-and-fire neuron stage directly downstream of the MAC unit.

---
 rtl/snn_neuron_pkg.sv | 30 +++
 rtl/fp32_add.sv | 105 ++++++++++
 rtl/lif_neuron_fp32.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/snn_neuron_pkg.sv
// Shared fp32 field layout, state encoding and helpers for the LIF neuron stage.
package snn_neuron_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;
  localparam int ADDR_W   = 12;

  localparam logic [FP_W-1:0]  FP32_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0]  FP32_QNAN = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DECAY = 2'd1,
    ST_INTEG = 2'd2,
    ST_CHECK = 2'd3
  } lif_state_e;

  function automatic logic fp32_is_special(input logic [FP_W-1:0] x);
    return x[30:23] == EXP_MAX;
  endfunction

  function automatic logic fp32_is_zero(input logic [FP_W-1:0] x);
    return x[30:23] == 8'h00;
  endfunction

endpackage

// File: rtl/fp32_add.sv
// Shared fp32 adder/subtractor: round-to-nearest-even, subnormals flushed to +0,
// one registered cycle of latency.
module fp32_add
  import snn_neuron_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic            sub_i,
  output logic [FP_W-1:0] sum_o
);

  logic [FP_W-1:0] a_s, b_s, big_s, lit_s, res_s, sum_q;
  logic [26:0]     m_big_s, m_lit_s, m_sh_s, mask_s, dif_s, norm_s;
  logic [27:0]     add_s;
  logic [7:0]      e_diff_s;
  logic [4:0]      lz_s;
  logic signed [9:0] exp_n_s, exp_r_s;
  logic [24:0]     mant_r_s;
  logic [22:0]     frac_s;
  logic            eff_sub_s, rnd_up_s;

  // Align, add/subtract, normalise, round and pick the special-case result.
  always_comb begin
    a_s = a_i;
    b_s = {b_i[31] ^ sub_i, b_i[30:0]};
    if (b_s[30:0] > a_s[30:0]) begin
      big_s = b_s;
      lit_s = a_s;
    end else begin
      big_s = a_s;
      lit_s = b_s;
    end
    eff_sub_s = big_s[31] ^ lit_s[31];
    m_big_s   = {1'b1, big_s[22:0], 3'b000};
    m_lit_s   = {1'b1, lit_s[22:0], 3'b000};
    e_diff_s  = big_s[30:23] - lit_s[30:23];
    mask_s    = 27'd0;
    // Bits shifted out of the smaller operand collapse into the sticky bit.
    if (e_diff_s > 8'd26) begin
      m_sh_s = 27'd1;
    end else begin
      mask_s = (27'd1 << e_diff_s) - 27'd1;
      m_sh_s = (m_lit_s >> e_diff_s) | {26'd0, |(m_lit_s & mask_s)};
    end
    add_s = {1'b0, m_big_s} + {1'b0, m_sh_s};
    dif_s = m_big_s - m_sh_s;
    lz_s  = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (dif_s[i]) lz_s = 5'(26 - i);
    end
    if (eff_sub_s) begin
      norm_s  = dif_s << lz_s;
      exp_n_s = $signed({2'b00, big_s[30:23]}) - $signed({5'd0, lz_s});
    end else if (add_s[27]) begin
      norm_s  = {add_s[27:2], add_s[1] | add_s[0]};
      exp_n_s = $signed({2'b00, big_s[30:23]}) + 10'sd1;
    end else begin
      norm_s  = add_s[26:0];
      exp_n_s = $signed({2'b00, big_s[30:23]});
    end
    rnd_up_s = norm_s[2] & (norm_s[3] | norm_s[1] | norm_s[0]);
    mant_r_s = {1'b0, norm_s[26:3]} + {24'd0, rnd_up_s};
    if (mant_r_s[24]) begin
      exp_r_s = exp_n_s + 10'sd1;
      frac_s  = mant_r_s[23:1];
    end else begin
      exp_r_s = exp_n_s;
      frac_s  = mant_r_s[22:0];
    end
    if (fp32_is_special(a_s) || fp32_is_special(b_s)) begin
      if ((fp32_is_special(a_s) && a_s[22:0] != 23'd0) ||
          (fp32_is_special(b_s) && b_s[22:0] != 23'd0) ||
          (fp32_is_special(a_s) && fp32_is_special(b_s) && a_s[31] != b_s[31])) begin
        res_s = FP32_QNAN;
      end else if (fp32_is_special(a_s)) begin
        res_s = a_s;
      end else begin
        res_s = b_s;
      end
    end else if (fp32_is_zero(a_s) && fp32_is_zero(b_s)) begin
      res_s = FP32_ZERO;
    end else if (fp32_is_zero(a_s)) begin
      res_s = b_s;
    end else if (fp32_is_zero(b_s)) begin
      res_s = a_s;
    end else if (exp_r_s >= 10'sd255) begin
      res_s = {big_s[31], EXP_MAX, 23'd0};
    end else if (exp_r_s <= 10'sd0 || (eff_sub_s && dif_s == 27'd0)) begin
      res_s = FP32_ZERO;
    end else begin
      res_s = {big_s[31], exp_r_s[7:0], frac_s};
    end
  end

  // Result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= FP32_ZERO;
    else       sum_q <= res_s;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/lif_neuron_fp32.sv
// fp32 leaky integrate-and-fire neuron: decay, integrate, threshold, spike.
// Optional refractory period is built when LIF_REFRACTORY_EN is defined.
module lif_neuron_fp32
  import snn_neuron_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NEURON_ADDRESS = 12'd7,
  parameter logic [FP_W-1:0]   THRESHOLD      = 32'h42C8_0000,
  parameter logic [FP_W-1:0]   V_RESET        = 32'h0000_0000,
  parameter int                DECAY_SHIFT    = 3
`ifdef LIF_REFRACTORY_EN
  ,parameter int               REFRACTORY_STEPS = 2
`endif
)(
  input  logic              CLK_Neuron,
  input  logic              RST_Neuron,
  input  logic              in_valid,
  input  logic [FP_W-1:0]   in_data,
  output logic              spike_out,
  output logic [ADDR_W-1:0] spike_address,
  output logic [FP_W-1:0]   v_mem,
  output logic              busy,
  output logic              overflow_err
);

  localparam logic [7:0] SHIFT_EXP = 8'(DECAY_SHIFT);

  lif_state_e        state_q, state_d;
  logic [FP_W-1:0]   v_q, v_d, data_q, data_d, pend_data_q, pend_data_d;
  logic              pend_q, pend_d, ovf_q, ovf_d, spike_q, spike_d, busy_q;
  logic              skip_q, skip_d, fire_s, start_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FP_W-1:0]   start_data_s, vs_s, add_a_s, add_b_s, sum_s;
  logic              add_sub_s;
`ifdef LIF_REFRACTORY_EN
  localparam logic [2:0] REFR_RELOAD = 3'(REFRACTORY_STEPS);
  logic [2:0] refr_q, refr_d, refr_eff_s;
`endif

  // Leak term: v scaled by 2^-DECAY_SHIFT via the exponent alone.
  always_comb begin
    if (v_q[30:23] <= SHIFT_EXP) vs_s = FP32_ZERO;
    else                         vs_s = {v_q[31], v_q[30:23] - SHIFT_EXP, v_q[22:0]};
  end

  // Adder operand mux: DECAY forms v - vs, otherwise decayed_v + input.
  always_comb begin
    if (state_q == ST_DECAY) begin
      add_a_s   = v_q;
      add_b_s   = vs_s;
      add_sub_s = 1'b1;
    end else begin
      add_a_s   = sum_s;
      add_b_s   = data_q;
      add_sub_s = 1'b0;
    end
  end

  fp32_add u_add (
    .clk_i (CLK_Neuron),
    .rst_i (RST_Neuron),
    .a_i   (add_a_s),
    .b_i   (add_b_s),
    .sub_i (add_sub_s),
    .sum_o (sum_s)
  );

  // Next-state, pending-slot and output logic.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    data_d       = data_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    ovf_d        = ovf_q;
    spike_d      = 1'b0;
    addr_d       = '0;
    skip_d       = skip_q;
    fire_s       = 1'b0;
    start_s      = 1'b0;
    start_data_s = in_data;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) start_s = 1'b1;
        else          state_d = ST_IDLE;
      end
      ST_DECAY: state_d = ST_INTEG;
      ST_INTEG: state_d = ST_CHECK;
      ST_CHECK: begin
        if (skip_q) fire_s = 1'b0;
        else fire_s = (!sum_s[31] && sum_s[30:0] >= THRESHOLD[30:0]) || fp32_is_special(sum_s);
        if (fire_s)      v_d = V_RESET;
        else if (skip_q) v_d = v_q;
        else             v_d = sum_s;
        spike_d = fire_s;
        addr_d  = fire_s ? NEURON_ADDRESS : '0;
        if (pend_q) begin
          start_s      = 1'b1;
          start_data_s = pend_data_q;
        end else if (in_valid) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // CHECK consumes the pending slot, so an arrival that cycle is never dropped.
    if (state_q == ST_CHECK) begin
      pend_d = pend_q & in_valid;
      if (pend_q && in_valid) pend_data_d = in_data;
      else                    pend_data_d = pend_data_q;
    end else if (in_valid && state_q != ST_IDLE) begin
      if (!pend_q) begin
        pend_d      = 1'b1;
        pend_data_d = in_data;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      pend_d = pend_q;
    end
`ifdef LIF_REFRACTORY_EN
    refr_eff_s = fire_s ? REFR_RELOAD : refr_q;
    refr_d     = refr_eff_s;
`endif
    if (start_s) begin
      data_d = start_data_s;
`ifdef LIF_REFRACTORY_EN
      if (refr_eff_s != 3'd0) begin
        skip_d  = 1'b1;
        refr_d  = refr_eff_s - 3'd1;
        state_d = ST_CHECK;
      end else begin
        skip_d  = 1'b0;
        state_d = ST_DECAY;
      end
`else
      skip_d  = 1'b0;
      state_d = ST_DECAY;
`endif
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_Neuron or posedge RST_Neuron) begin
    if (RST_Neuron) begin
      state_q     <= ST_IDLE;
      v_q         <= V_RESET;
      data_q      <= FP32_ZERO;
      pend_q      <= 1'b0;
      pend_data_q <= FP32_ZERO;
      ovf_q       <= 1'b0;
      spike_q     <= 1'b0;
      addr_q      <= '0;
      skip_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LIF_REFRACTORY_EN
      refr_q      <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
      spike_q     <= spike_d;
      addr_q      <= addr_d;
      skip_q      <= skip_d;
      busy_q      <= (state_d != ST_IDLE);
`ifdef LIF_REFRACTORY_EN
      refr_q      <= refr_d;
`endif
    end
  end

  assign v_mem         = v_q;
  assign spike_out     = spike_q;
  assign spike_address = addr_q;
  assign busy          = busy_q;
  assign overflow_err  = ovf_q;

endmodule
